// File: rtl/my_shift_reg.sv
// Multi-stage register (WIDTH x DEPTH) with per-stage valid bits: hold, forward/backward shift, parallel load.
// Optional per-stage even parity with a sticky error flag when MY_SHIFT_REG_PARITY_EN is defined.
module my_shift_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [WIDTH*DEPTH-1:0]     load_data,
    input  logic [$clog2(DEPTH)-1:0]   tap_sel,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           tap_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
`ifdef MY_SHIFT_REG_PARITY_EN
    ,
    input  logic                       par_inject,
    output logic                       parity_err
`endif
);

    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_FWD  = 2'b01,
        MODE_BACK = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign mode_s = mode_e'(mode);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        valid_d = valid_q;
        unique case (mode_s)
            MODE_HOLD: ;
            MODE_FWD: begin
                stage_d[0] = data_in;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
                valid_d = {valid_q[DEPTH-2:0], 1'b1};
            end
            MODE_BACK: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    stage_d[i] = stage_q[i+1];
                end
                stage_d[DEPTH-1] = '0;
                valid_d = {1'b0, valid_q[DEPTH-1:1]};
            end
            MODE_LOAD: begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_d[i] = load_data[i*WIDTH +: WIDTH];
                end
                valid_d = '1;
            end
            default: ;
        endcase
    end

    // Count is the popcount of the next valid vector so it lands on the same edge as valid.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Out-of-range selects (non-power-of-2 DEPTH) fall through to zero.
    always_comb begin
        tap_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == SEL_W'(i)) begin
                tap_out = stage_q[i];
            end
        end
    end

    assign out       = stage_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

`ifdef MY_SHIFT_REG_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
    logic             err_q, err_d;
    logic             err_now;

    always_comb begin
        par_d = par_q;
        unique case (mode_s)
            MODE_HOLD: ;
            MODE_FWD:  par_d = {par_q[DEPTH-2:0], (^data_in) ^ par_inject};
            MODE_BACK: par_d = {1'b0, par_q[DEPTH-1:1]};
            MODE_LOAD: begin
                for (int i = 0; i < DEPTH; i++) begin
                    par_d[i] = ^load_data[i*WIDTH +: WIDTH];
                end
            end
            default: ;
        endcase
    end

    // The flag reflects the current tail immediately and then sticks until reset.
    assign err_now    = valid_q[DEPTH-1] & (par_q[DEPTH-1] != ^stage_q[DEPTH-1]);
    assign err_d      = err_q | err_now;
    assign parity_err = err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= '0;
            err_q <= 1'b0;
        end else begin
            par_q <= par_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_my_shift_reg.sv
// Directed bench for my_shift_reg (WIDTH=8, DEPTH=4); parity checks compile in with MY_SHIFT_REG_PARITY_EN.
module tb_my_shift_reg;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_FWD  = 2'b01;
    localparam logic [1:0] M_BACK = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  data_in = 8'h00;
    logic [31:0] load_data = 32'h0;
    logic [1:0]  tap_sel = 2'd0;
    logic [7:0]  out;
    logic        out_valid;
    logic [7:0]  tap_out;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        par_inject = 1'b0;
`ifdef MY_SHIFT_REG_PARITY_EN
    logic        parity_err;
`endif

    int checks = 0;
    int errors = 0;

    // {perr, tap, count, out_valid, out}
    logic [20:0] exp_q [$];

    my_shift_reg #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .data_in   (data_in),
        .load_data (load_data),
        .tap_sel   (tap_sel),
        .out       (out),
        .out_valid (out_valid),
        .tap_out   (tap_out),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef MY_SHIFT_REG_PARITY_EN
        ,
        .par_inject(par_inject),
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge's inputs, queue the expected post-edge view, then compare after the edge.
    task automatic step(input string tag, input logic [1:0] m, input logic [7:0] din,
                        input logic [31:0] ld, input logic [1:0] sel, input logic rst,
                        input logic inj, input logic [7:0] e_out, input logic e_ov,
                        input logic [2:0] e_cnt, input logic [7:0] e_tap, input logic e_perr);
        logic [20:0] e;
        mode       = m;
        data_in    = din;
        load_data  = ld;
        tap_sel    = sel;
        reset      = rst;
        par_inject = inj;
        exp_q.push_back({e_perr, e_tap, e_cnt, e_ov, e_out});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".out"},       {24'h0, out},        {24'h0, e[7:0]});
        chk({tag, ".out_valid"}, {31'h0, out_valid},  {31'h0, e[8]});
        chk({tag, ".count"},     {29'h0, count},      {29'h0, e[11:9]});
        chk({tag, ".full"},      {31'h0, full},       {31'h0, (e[11:9] == 3'd4)});
        chk({tag, ".empty"},     {31'h0, empty},      {31'h0, (e[11:9] == 3'd0)});
        chk({tag, ".tap_out"},   {24'h0, tap_out},    {24'h0, e[19:12]});
`ifdef MY_SHIFT_REG_PARITY_EN
        chk({tag, ".parity_err"}, {31'h0, parity_err}, {31'h0, e[20]});
`endif
    endtask

    initial begin
        logic [31:0] ld_word;
        logic [7:0]  ld_bytes [4];
        int          s;

        // Reset, then HOLD keeps everything cleared.
        step("rst",   M_HOLD, 8'h00, 32'h0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hold0", M_HOLD, 8'hFF, 32'hFFFF_FFFF, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        end

        // Fill forward.
        step("fwd1", M_FWD, 8'h11, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 8'h11, 1'b0);
        step("fwd2", M_FWD, 8'h22, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h22, 1'b0);
        step("fwd3", M_FWD, 8'h33, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 8'h33, 1'b0);
        step("fwd4", M_FWD, 8'h44, 32'h0, 2'd0, 1'b0, 1'b0, 8'h11, 1'b1, 3'd4, 8'h44, 1'b0);
        // Shift when full drops the tail.
        step("fwd5", M_FWD, 8'h55, 32'h0, 2'd0, 1'b0, 1'b0, 8'h22, 1'b1, 3'd4, 8'h55, 1'b0);

        // Drain backward, then shift back when already empty.
        step("back1", M_BACK, 8'h99, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 8'h44, 1'b0);
        step("back2", M_BACK, 8'h99, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h33, 1'b0);
        step("back3", M_BACK, 8'h99, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 8'h22, 1'b0);
        step("back4", M_BACK, 8'h99, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        step("back5", M_BACK, 8'h99, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);

        // Parallel load, random tap reads during HOLD.
        ld_word = 32'hDDCC_BBAA;
        for (int i = 0; i < 4; i++) ld_bytes[i] = ld_word[i*8 +: 8];
        step("load1", M_LOAD, 8'h00, ld_word, 2'd1, 1'b0, 1'b0, 8'hDD, 1'b1, 3'd4, 8'hBB, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s = $urandom_range(0, 3);
            step("tap", M_HOLD, 8'h5A, 32'h1234_5678, 2'(s), 1'b0, 1'b0, 8'hDD, 1'b1, 3'd4, ld_bytes[s], 1'b0);
        end
        // Load when full overwrites everything.
        step("load2", M_LOAD, 8'h00, 32'h0403_0201, 2'd0, 1'b0, 1'b0, 8'h04, 1'b1, 3'd4, 8'h01, 1'b0);
        // Reset wins over LOAD.
        step("rst_ld", M_LOAD, 8'h00, 32'hFFFF_FFFF, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        step("post_rst", M_FWD, 8'h5A, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 8'h5A, 1'b0);

        // Parity stream: corrupt word enters, flags when it reaches the tail, sticks through HOLD.
        step("prst", M_HOLD, 8'h00, 32'h0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        step("par1", M_FWD, 8'hA5, 32'h0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 8'hA5, 1'b0);
        step("par2", M_FWD, 8'h01, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h01, 1'b0);
        step("par3", M_FWD, 8'h02, 32'h0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 8'h02, 1'b0);
        step("par4", M_FWD, 8'h03, 32'h0, 2'd0, 1'b0, 1'b0, 8'hA5, 1'b1, 3'd4, 8'h03, 1'b1);
        step("par_hold", M_HOLD, 8'h00, 32'h0, 2'd3, 1'b0, 1'b0, 8'hA5, 1'b1, 3'd4, 8'hA5, 1'b1);
        // Clean word pushes the bad one out; flag remains sticky.
        step("par5", M_FWD, 8'h07, 32'h0, 2'd0, 1'b0, 1'b0, 8'h01, 1'b1, 3'd4, 8'h07, 1'b1);
        step("par_rst", M_HOLD, 8'h00, 32'h0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        // Clean load leaves the flag clear.
        step("par_ld", M_LOAD, 8'h00, 32'h8070_3F01, 2'd2, 1'b0, 1'b0, 8'h80, 1'b1, 3'd4, 8'h70, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
